// File: rtl/c_conn_pkg.sv
// c_conn_pkg: shared helpers for the connection-holding stage.
// Holds the watchdog counter-width function and the row-major index
// helpers used to address the num_ports x num_ports request/grant matrices.
package c_conn_pkg;

  // Bits needed to count from 0 up to and including 'cycles'.
  function automatic int conn_cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  // Flat row-major index of matrix element (row, col).
  function automatic int conn_idx(input int row, input int col, input int n);
    return row * n + col;
  endfunction

  // Row of a flat row-major index.
  function automatic int conn_row(input int idx, input int n);
    return idx / n;
  endfunction

  // Column of a flat row-major index.
  function automatic int conn_col(input int idx, input int n);
    return idx % n;
  endfunction

endpackage

// File: rtl/c_conn_wdog.sv
// c_conn_wdog: idle watchdog for one crossbar input.
// Counts cycles in which the input holds a connection but moves no flit.
// When the count reaches wdog_cycles the held row is released and a
// one-cycle error pulse is raised, unless a tail releases it that cycle.
// Only instantiated when C_CONN_WDOG_EN is defined.
module c_conn_wdog
  import c_conn_pkg::*;
#(
  parameter int wdog_cycles = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic held,
  input  logic flit_valid,
  input  logic flit_tail,
  output logic expire,
  output logic wdog_err
);

  localparam int cnt_w = conn_cnt_width(wdog_cycles);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(wdog_cycles);

  logic [cnt_w-1:0] cnt_reg;
  logic             err_reg;

  // Expiry only counts while the row is actually held; a stale count left
  // over from the release cycle must not fire again.
  assign expire   = held & (cnt_reg == cnt_max);
  assign wdog_err = err_reg;

  // Saturating idle counter plus error pulse; frozen while inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else if (active) begin
      if (flit_valid | ~held)
        cnt_reg <= '0;
      else if (cnt_reg != cnt_max)
        cnt_reg <= cnt_reg + cnt_w'(1);
      err_reg <= expire & ~(flit_valid & flit_tail);
    end
  end

endmodule

// File: rtl/c_wf_conn_hold.sv
// c_wf_conn_hold: connection-holding stage behind the wavefront allocator.
// Latches each granted input->output connection of a multi-flit packet
// until its tail passes, masks held inputs/outputs out of the request
// matrix fed back to the allocator, and drives per-output crossbar selects.
// Optional feature: define C_CONN_WDOG_EN to build a per-input idle
// watchdog that tears down stalled connections.
module c_wf_conn_hold
  import c_conn_pkg::*;
#(
  parameter int num_ports   = 8,
  parameter int wdog_cycles = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           active,
  input  logic [num_ports*num_ports-1:0] req_in,
  output logic [num_ports*num_ports-1:0] req_out,
  input  logic [num_ports*num_ports-1:0] gnt,
  output logic                           alloc_update,
  input  logic [num_ports-1:0]           flit_valid,
  input  logic [num_ports-1:0]           flit_tail,
  output logic [num_ports*num_ports-1:0] xbar_sel,
  output logic [num_ports-1:0]           in_busy,
  output logic [num_ports-1:0]           out_busy,
  output logic [num_ports-1:0]           wdog_err
);

  localparam int np = num_ports;

  if (num_ports < 2) begin : g_bad_ports
    $error("c_wf_conn_hold: num_ports must be >= 2");
  end
  if (wdog_cycles < 1) begin : g_bad_wdog
    $error("c_wf_conn_hold: wdog_cycles must be >= 1");
  end

  logic [np*np-1:0] conn_reg;
  logic [np*np-1:0] conn_next;
  logic [np-1:0]    col_bits [np];
  logic [np-1:0]    row_release;
  logic [np-1:0]    row_take;
  logic [np-1:0]    expire;

  // The head flit routes through the grant itself; held rows route via conn.
  assign xbar_sel     = conn_reg | gnt;
  assign alloc_update = active & (|gnt);

  genvar gi, gj;
  for (gi = 0; gi < np; gi++) begin : g_row
    for (gj = 0; gj < np; gj++) begin : g_col
      assign req_out[conn_idx(gi, gj, np)] =
        req_in[conn_idx(gi, gj, np)] & ~in_busy[gi] & ~out_busy[gj];
      // Transposed copy so each output's column can be OR-reduced.
      assign col_bits[gj][gi] = conn_reg[conn_idx(gi, gj, np)];
    end

    assign in_busy[gi]  = |conn_reg[gi*np +: np];
    assign out_busy[gi] = |col_bits[gi];

    // A held row drops on its tail or on watchdog expiry. A free row only
    // latches a grant that arrives with a non-tail head flit; grants on a
    // busy row or onto a busy column are ignored for the conn update.
    assign row_release[gi] = (flit_valid[gi] & flit_tail[gi]) | expire[gi];
    assign row_take[gi]    = flit_valid[gi] & ~flit_tail[gi];
    assign conn_next[gi*np +: np] =
      in_busy[gi] ? (row_release[gi] ? {np{1'b0}} : conn_reg[gi*np +: np])
                  : (row_take[gi] ? (gnt[gi*np +: np] & ~out_busy) : {np{1'b0}});
  end

`ifdef C_CONN_WDOG_EN
  for (gi = 0; gi < np; gi++) begin : g_wdog
    c_conn_wdog #(
      .wdog_cycles (wdog_cycles)
    ) u_wdog (
      .clk        (clk),
      .reset      (reset),
      .active     (active),
      .held       (in_busy[gi]),
      .flit_valid (flit_valid[gi]),
      .flit_tail  (flit_tail[gi]),
      .expire     (expire[gi]),
      .wdog_err   (wdog_err[gi])
    );
  end
`else
  assign expire   = '0;
  assign wdog_err = '0;
`endif

  // Connection matrix: cleared by reset, frozen while inactive.
  always_ff @(posedge clk) begin
    if (reset)
      conn_reg <= '0;
    else if (active)
      conn_reg <= conn_next;
  end

endmodule

// File: doc/c_wf_conn_hold.md
# c_wf_conn_hold

Connection-holding stage directly downstream of the wavefront switch allocator. It consumes the allocator's combined grant matrix and keeps each granted input→output crossbar connection until the packet's tail flit passes. It masks held inputs and outputs out of the request matrix fed back into the allocator, and drives per-output crossbar selects. An optional per-connection watchdog tears down connections that stall.

## Interface
- num_ports, 8, crossbar input/output count; must be ≥2
- wdog_cycles, 64, idle cycles before the watchdog releases a held connection; must be ≥1
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- active  in  1  enable for state updates; when 0, all registers hold
- req_in  in  num_ports*num_ports  raw request matrix, row-major [i*num_ports+o]
- req_out  out  num_ports*num_ports  masked request matrix to the allocator
- gnt  in  num_ports*num_ports  combined grant matrix from the allocator
- alloc_update  out  1  priority-update strobe to the allocator
- flit_valid  in  num_ports  a flit crosses from input i this cycle
- flit_tail  in  num_ports  that flit is a tail (qualified by flit_valid)
- xbar_sel  out  num_ports*num_ports  crossbar select; column o is one-hot or zero
- in_busy  out  num_ports  input i holds a connection (registered view)
- out_busy  out  num_ports  output o is held (registered view)
- wdog_err  out  num_ports  one-cycle pulse when the watchdog releases input i's connection (0 when the watchdog is compiled out)

## Operation
- State: a conn register matrix, num_ports², all 0 at reset. At most one bit is set per row and per column.
- in_busy[i] = OR of row i of conn. out_busy[o] = OR of column o of conn.
- req_out[i,o] = req_in[i,o] & ~in_busy[i] & ~out_busy[o], combinational.
- xbar_sel = conn | gnt, combinational. A head flit routes in its grant cycle.
- alloc_update = active & (|gnt).
- Grant at (i,o), with flit_valid[i] required in the same cycle:
  - flit_tail[i]=1 (single-flit packet): conn is not set.
  - otherwise: conn[i,o] ← 1 next cycle.
- Held row i with flit_valid[i] & flit_tail[i]: row i clears next cycle.
- A grant on a busy input or output cannot occur because of the masking. If gnt hits a busy row or column, the grant is ignored for conn update and xbar_sel still ORs it; this is undefined traffic and the verifier flags it.
- Multiple grants in one row or column are illegal input. This is not checked in RTL.
- When active=0: conn, the watchdog counters and wdog_err hold; alloc_update=0.
- Reset mid-packet clears all connections immediately on the next edge. Upstream is responsible for flushing its own state.

## Timing
- Grant → conn visible (in_busy/out_busy/req_out mask): 1 cycle.
- Tail → release visible: 1 cycle. An output freed by a tail in cycle t can be re-granted at earliest in cycle t+1.
- Tail and a new request for the same output in the same cycle: the request stays masked in that cycle.
- Reset values: in_busy=0, out_busy=0, xbar_sel=gnt, req_out=req_in, alloc_update=active&|gnt, wdog_err=0.

## Configuration
- C_CONN_WDOG_EN defined:
  - Each input has an idle counter, $clog2(wdog_cycles+1) bits, cleared at reset.
  - The counter is cleared on flit_valid[i] or when the row is not held. It increments when the row is held and flit_valid[i]=0 (saturating).
  - When the counter equals wdog_cycles, row i clears next cycle and wdog_err[i] pulses for one cycle.
  - Tail and expiry in the same cycle: the release happens once, and wdog_err stays 0.
- C_CONN_WDOG_EN undefined: no counters are built, wdog_err is tied to 0, and connections hold indefinitely.

## Structure
- The shared package c_conn_pkg holds:
  - the counter-width function
  - the row/column index helpers
- Sub-module c_conn_wdog, one instance per input, generated only under C_CONN_WDOG_EN.
- The top module holds the conn matrix, the masking and the select logic.

## Test plan
All scenarios use num_ports=4, wdog_cycles=8.
- Reset: assert reset for 2 cycles with req_in all-ones → req_out all-ones, in_busy=0, out_busy=0, wdog_err=0.
- Multi-flit hold: gnt[1,2] with a head flit (no tail), then 3 body flits, then a tail →
  - in_busy[1] and out_busy[2] are 1 from the cycle after the grant through the tail cycle, and 0 the cycle after;
  - req_out row 1 and column 2 read 0 while held;
  - xbar_sel[1,2]=1 throughout.
- Single-flit packet: gnt[0,3] with a head+tail flit → conn never set; out_busy[3] stays 0; req_in[2,3] passes to req_out in the next cycle.
- Back-to-back reuse: tail on input 1 (held to 2) in cycle t while req_in[3,2]=1 → req_out[3,2]=0 at t and 1 at t+1.
- Active gating: hold with active=0 for 10 cycles with no flits → conn unchanged, wdog_err=0, alloc_update=0.
- Watchdog (C_CONN_WDOG_EN defined): hold on input 0, then no flits for 8 cycles → wdog_err[0] pulses once and in_busy[0]=0 on the following cycle. With the macro undefined, the connection stays held.
